// File: rtl/booth_divider_if.sv
// Handshake and operand/result bundle between the MAC controller and booth_divider.
// The controller drives through the master modport; the divider attaches as slave.
interface booth_divider_if #(
    parameter int DATA_WIDTH = 9
);
    logic                           start_in;
    logic signed [2*DATA_WIDTH-1:0] dividendo_in;
    logic signed [DATA_WIDTH-1:0]   divisor_in;
    logic signed [DATA_WIDTH-1:0]   cociente_out;
    logic signed [DATA_WIDTH-1:0]   residuo_out;
    logic                           flag_out;
    logic                           busy_out;
    logic                           done_out;

    modport master (
        output start_in, dividendo_in, divisor_in,
        input  cociente_out, residuo_out, flag_out, busy_out, done_out
    );

    modport slave (
        input  start_in, dividendo_in, divisor_in,
        output cociente_out, residuo_out, flag_out, busy_out, done_out
    );
endinterface

// File: rtl/booth_divider.sv
// Sequential signed divider: 2N-bit dividend by N-bit divisor, restoring division on
// magnitudes at one quotient bit per clock, with signs and range applied at the end.
module booth_divider #(
    parameter int DATA_WIDTH = 9
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    booth_divider_if.slave  bus
);
    localparam int N  = DATA_WIDTH;
    localparam int CW = $clog2(N + 1);

    localparam logic [N-1:0] Q_POS_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] Q_NEG_MAX = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_quo;
    logic [N:0]    r_dvs;
    logic          r_sign_q;
    logic          r_sign_r;
    logic          r_err;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_cociente;
    logic [N-1:0]  r_residuo;
    logic          r_flag;
    logic          r_busy;
    logic          r_done;

    // Magnitudes are one bit wider than the operands so the most negative values do not wrap.
    logic [2*N:0]  w_dvd_ext;
    logic [2*N:0]  w_dvd_mag;
    logic [N:0]    w_dvs_ext;
    logic [N:0]    w_dvs_mag;
    logic          w_err_in;

    assign w_dvd_ext = {bus.dividendo_in[2*N-1], bus.dividendo_in};
    assign w_dvd_mag = bus.dividendo_in[2*N-1] ? -w_dvd_ext : w_dvd_ext;
    assign w_dvs_ext = {bus.divisor_in[N-1], bus.divisor_in};
    assign w_dvs_mag = bus.divisor_in[N-1] ? -w_dvs_ext : w_dvs_ext;
    assign w_err_in  = (bus.divisor_in == '0) || (w_dvd_mag[2*N:N] >= w_dvs_mag);

    // Partial remainder stays below |divisor|, so the trial difference fits N+1 signed bits
    // and its top bit alone tells whether the subtraction succeeded.
    logic [N:0]    w_shift;
    logic [N:0]    w_diff;
    logic          w_ge;

    assign w_shift = {r_rem, r_quo[N-1]};
    assign w_diff  = w_shift - r_dvs;
    assign w_ge    = ~w_diff[N];

    logic [N-1:0]  w_q_signed;
    logic [N-1:0]  w_r_signed;
    logic          w_q_over;

    assign w_q_signed = r_sign_q ? -r_quo : r_quo;
    assign w_r_signed = r_sign_r ? -r_rem : r_rem;
    assign w_q_over   = r_sign_q ? (r_quo > Q_NEG_MAX) : (r_quo > Q_POS_MAX);

    // NOTE: every register here, datapath included, is cleared by the async reset so a
    // reset mid-operation leaves no stale operand state behind.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= S_IDLE;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_err      <= 1'b0;
            r_count    <= '0;
            r_cociente <= '0;
            r_residuo  <= '0;
            r_flag     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start_in) begin
                        r_rem    <= w_dvd_mag[2*N-1:N];
                        r_quo    <= w_dvd_mag[N-1:0];
                        r_dvs    <= w_dvs_mag;
                        r_sign_q <= bus.dividendo_in[2*N-1] ^ bus.divisor_in[N-1];
                        r_sign_r <= bus.dividendo_in[2*N-1];
                        r_err    <= w_err_in;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem   <= w_ge ? w_diff[N-1:0] : w_shift[N-1:0];
                    r_quo   <= {r_quo[N-2:0], w_ge};
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(N - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (r_err || w_q_over) begin
                        r_cociente <= '0;
                        r_residuo  <= '0;
                        r_flag     <= 1'b1;
                    end else begin
                        r_cociente <= w_q_signed;
                        r_residuo  <= w_r_signed;
                        r_flag     <= 1'b0;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cociente_out = r_cociente;
    assign bus.residuo_out  = r_residuo;
    assign bus.flag_out     = r_flag;
    assign bus.busy_out     = r_busy;
    assign bus.done_out     = r_done;
endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider: a cycle-level reference built on SV / and %,
// compared every cycle, plus directed vectors with hand-computed results.
module tb_booth_divider;
    localparam int N = 9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    booth_divider_if #(.DATA_WIDTH(N)) bus ();

    booth_divider #(.DATA_WIDTH(N)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference result: truncating division, error when divisor is zero or the
    // quotient does not fit a signed N-bit value.
    function automatic void model_div(input logic signed [2*N-1:0] a,
                                      input logic signed [N-1:0] b,
                                      output logic signed [N-1:0] q,
                                      output logic signed [N-1:0] r,
                                      output logic f);
        longint la, lb, qq, rr;
        la = longint'(a);
        lb = longint'(b);
        q = '0;
        r = '0;
        f = 1'b1;
        if (lb != 0) begin
            qq = la / lb;
            rr = la % lb;
            if (qq <= 255 && qq >= -256) begin
                q = N'(qq);
                r = N'(rr);
                f = 1'b0;
            end
        end
    endfunction

    logic signed [N-1:0]   exp_q    = '0;
    logic signed [N-1:0]   exp_r    = '0;
    logic                  exp_f    = 1'b0;
    logic                  exp_busy = 1'b0;
    logic                  exp_done = 1'b0;
    int                    m_left   = 0;
    logic signed [2*N-1:0] m_dvd    = '0;
    logic signed [N-1:0]   m_dvs    = '0;

    // Countdown reference: an accepted request completes N+1 edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q = '0; exp_r = '0; exp_f = 1'b0;
            exp_busy = 1'b0; exp_done = 1'b0; m_left = 0;
        end else if (m_left == 0) begin
            exp_done = 1'b0;
            if (bus.start_in) begin
                m_dvd    = bus.dividendo_in;
                m_dvs    = bus.divisor_in;
                m_left   = N + 1;
                exp_busy = 1'b1;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                model_div(m_dvd, m_dvs, exp_q, exp_r, exp_f);
                exp_busy = 1'b0;
                exp_done = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("cyc_busy", bus.busy_out, exp_busy);
        check("cyc_done", bus.done_out, exp_done);
        check("cyc_flag", bus.flag_out, exp_f);
        check("cyc_q", bus.cociente_out, exp_q);
        check("cyc_r", bus.residuo_out, exp_r);
    end

    task automatic launch(input logic signed [2*N-1:0] a, input logic signed [N-1:0] b);
        @(negedge clk);
        bus.start_in     = 1'b1;
        bus.dividendo_in = a;
        bus.divisor_in   = b;
        @(negedge clk);
        bus.start_in     = 1'b0;
        bus.dividendo_in = (2*N)'($urandom);
        bus.divisor_in   = N'($urandom);
    endtask

    task automatic wait_done(input int start_n, output int n, output int nbusy);
        bit seen;
        seen  = 1'b0;
        n     = start_n;
        nbusy = bus.busy_out ? 1 : 0;
        while (!seen && n < start_n + 40) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.done_out) seen = 1'b1;
            else if (bus.busy_out) nbusy++;
        end
        check("done_seen", seen, 1);
    endtask

    task automatic check_res(input string name, input logic signed [N-1:0] q,
                             input logic signed [N-1:0] r, input logic f);
        check({name, "_q"}, bus.cociente_out, q);
        check({name, "_r"}, bus.residuo_out, r);
        check({name, "_flag"}, bus.flag_out, f);
    endtask

    typedef struct {
        logic signed [2*N-1:0] dvd;
        logic signed [N-1:0]   dvs;
        logic signed [N-1:0]   q;
        logic signed [N-1:0]   r;
        logic                  f;
    } vec_t;

    vec_t vecs [12] = '{
        '{-56,     7,    -8,    0, 1'b0},
        '{7,       -2,   -3,    1, 1'b0},
        '{-7,      2,    -3,   -1, 1'b0},
        '{-7,      -2,   3,    -1, 1'b0},
        '{5,       0,    0,     0, 1'b1},
        '{300,     1,    0,     0, 1'b1},
        '{255,     1,    255,   0, 1'b0},
        '{-256,    1,    -256,  0, 1'b0},
        '{256,     -1,   -256,  0, 1'b0},
        '{256,     1,    0,     0, 1'b1},
        '{-131072, -256, 0,     0, 1'b1},
        '{1000,    -9,   -111,  1, 1'b0}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nb, dones;
        logic signed [2*N-1:0] a;
        logic signed [N-1:0]   b;

        rst_n            = 1'b0;
        bus.start_in     = 1'b0;
        bus.dividendo_in = '0;
        bus.divisor_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_res("reset", 0, 0, 1'b0);
        check("reset_busy", bus.busy_out, 0);
        check("reset_done", bus.done_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            launch(vecs[i].dvd, vecs[i].dvs);
            wait_done(0, n, nb);
            check("vec_latency", n, 10);
            check("vec_busy_cycles", nb, 10);
            check_res("vec", vecs[i].q, vecs[i].r, vecs[i].f);
        end

        // Second request mid-operation is dropped.
        launch(1000, 7);
        repeat (3) @(negedge clk);
        bus.start_in     = 1'b1;
        bus.dividendo_in = -500;
        bus.divisor_in   = 3;
        @(negedge clk);
        bus.start_in = 1'b0;
        wait_done(4, n, nb);
        check("ignore_latency", n, 10);
        check_res("ignore", 142, 6, 1'b0);
        dones = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus.done_out || bus.busy_out) dones++;
        end
        check("ignore_no_second_op", dones, 0);

        // Back-to-back: start raised while done_out is high.
        launch(-1000, 7);
        wait_done(0, n, nb);
        check_res("b2b_first", -142, -6, 1'b0);
        @(negedge clk);
        check("b2b_done_high", bus.done_out, 1);
        bus.start_in     = 1'b1;
        bus.dividendo_in = 77;
        bus.divisor_in   = -5;
        @(negedge clk);
        bus.start_in = 1'b0;
        wait_done(0, n, nb);
        check("b2b_latency", n, 10);
        check_res("b2b_second", -15, 2, 1'b0);

        // Asynchronous reset between clock edges mid-operation.
        launch(5000, 50);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_res("async_rst", 0, 0, 1'b0);
        check("async_rst_busy", bus.busy_out, 0);
        check("async_rst_done", bus.done_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle_busy", bus.busy_out, 0);
        launch(100, 9);
        wait_done(0, n, nb);
        check("post_rst_latency", n, 10);
        check_res("post_rst", 11, 1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            a = (2*N)'($urandom);
            a = a >>> $urandom_range(0, 2*N - 1);
            b = N'($urandom);
            b = b >>> $urandom_range(0, N - 1);
            if ($urandom_range(0, 15) == 0) b = '0;
            launch(a, b);
            wait_done(0, n, nb);
            check("rand_latency", n, 10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
